// File: rtl/div_iter_pkg.sv
// Shared divider definitions: FSM state encodings and handshake levels used by div_iter and ex.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_iter_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Handshake levels shared with the execute stage
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit, compare-subtract against the divisor.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: rem_i partial remainder, bit_i next dividend bit, divisor_i divisor magnitude,
//        rem_o next partial remainder, q_bit_o quotient bit produced by this step.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i always holds, so trial < 2*divisor: a non-negative
  // difference fits in WIDTH bits and the top bit is a clean borrow flag.
  assign trial   = {rem_i, bit_i};
  assign diff    = trial - {1'b0, divisor_i};
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider with operand capture, divide-by-zero and early-out paths.
// Latency: WIDTH+1 cycles to ready_o (2 for divide-by-zero, 1 for early-out).
// Backpressure: result held in END while start_i stays high; annul_i aborts at any time.
// Ports: clk, rst (async active-low); sign_div_i/opdata1_i/opdata2_i/start_i sampled in FREE;
//        annul_i cancels; result_o = {remainder, quotient}; ready_o result valid; busy_o dividing.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sign_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic             signed_q;
  logic             neg1_q;
  logic             neg2_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  // Holds the dividend magnitude at start; quotient bits shift in from the LSB.
  logic [WIDTH-1:0] quo_q;

  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes at the capture edge
  assign neg1 = sign_div_i & opdata1_i[WIDTH-1];
  assign neg2 = sign_div_i & opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Sign fix-up applied to the last step's output. Most-negative / -1 falls
  // out naturally: magnitude quotient 1000..0, signs agree, so no negation.
  assign q_raw = {quo_q[WIDTH-2:0], step_q};
  assign q_fix = (signed_q & (neg1_q ^ neg2_q)) ? (~q_raw + 1'b1) : q_raw;
  assign r_fix = (signed_q & neg1_q) ? (~step_rem + 1'b1) : step_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      signed_q <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          busy_o   <= 1'b0;
          if (start_i == DIV_START && !annul_i) begin
            signed_q <= sign_div_i;
            neg1_q   <= neg1;
            neg2_q   <= neg2;
            dvs_q    <= mag2;
            rem_q    <= '0;
            quo_q    <= mag1;
            cnt      <= '0;
            if (opdata2_i == '0) begin
              state  <= DIV_BY_ZERO;
              busy_o <= 1'b1;
            end else if (EARLY_OUT && (mag1 < mag2)) begin
              // Quotient is zero and the remainder is the dividend as given.
              state <= DIV_END;
              rem_q <= opdata1_i;
              quo_q <= '0;
            end else begin
              state  <= DIV_ON;
              busy_o <= 1'b1;
            end
          end
        end

        DIV_BY_ZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state <= DIV_END;
            rem_q <= '0;
            quo_q <= '0;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state  <= DIV_FREE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state  <= DIV_END;
              busy_o <= 1'b0;
              rem_q  <= r_fix;
              quo_q  <= q_fix;
            end else begin
              rem_q <= step_rem;
              quo_q <= q_raw;
            end
          end
        end

        DIV_END: begin
          if (annul_i || start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            result_o <= {rem_q, quo_q};
            ready_o  <= DIV_RESULT_READY;
          end
        end

        default: begin
          state    <= DIV_FREE;
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
